// File: rtl/mux_sel_buf_if.sv
// Handshake bundle for mux_sel_buf: producer select/data side,
// consumer head-entry side and the sticky error flag.
interface mux_sel_buf_if #(
    parameter int WIDTH = 6,
    parameter int SEL_W = 3,
    parameter int N_IN  = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [SEL_W-1:0]      selector;
    logic [N_IN*WIDTH-1:0] data_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      data_out;
    logic [SEL_W-1:0]      out_sel;
    logic                  err_sel;
    logic                  err_clr;

    modport slave (
        input  in_valid, selector, data_in,
        input  out_ready, err_clr,
        output in_ready, out_valid,
        output data_out, out_sel, err_sel
    );

    modport master (
        output in_valid, selector, data_in,
        output out_ready, err_clr,
        input  in_ready, out_valid,
        input  data_out, out_sel, err_sel
    );
endinterface

// File: rtl/mux_sel_buf.sv
// Source-select mux with constant slot feeding a 2-entry FIFO;
// illegal codes fall back to source 0 and set a sticky error.
module mux_sel_buf #(
    parameter int WIDTH     = 6,
    parameter int SEL_W     = 3,
    parameter int N_IN      = 4,
    parameter int CONST_IDX = 1,
    parameter int CONST_VAL = 16
) (
    input logic           clk,
    input logic           reset,
    mux_sel_buf_if.slave  bus
);
    localparam logic [WIDTH-1:0] CVAL = WIDTH'(CONST_VAL);

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t     mem_q [2];
    logic       rd_ptr_q, rd_ptr_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic [1:0] cnt_q, cnt_d;
    logic       err_q, err_d;

    logic             sel_legal;
    logic [WIDTH-1:0] sel_val;
    logic             push, pop;
    entry_t           head;

    always_comb begin
        sel_legal = (int'(bus.selector) < N_IN);
        sel_val   = bus.data_in[WIDTH-1:0];
        for (int k = 0; k < N_IN; k++) begin
            if (int'(bus.selector) == k) begin
                sel_val = bus.data_in[k*WIDTH +: WIDTH];
            end
        end
        if (int'(bus.selector) == CONST_IDX) begin
            sel_val = CVAL;
        end
    end

    assign bus.in_ready  = (cnt_q != 2'd2) && !reset;
    assign bus.out_valid = (cnt_q != 2'd0);
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        cnt_d    = cnt_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        err_d    = err_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        // set beats clear when both happen together
        if (push && !sel_legal) begin
            err_d = 1'b1;
        end else if (bus.err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            err_q    <= err_d;
        end
    end

    // storage needs no reset; outputs are masked while empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{sel: bus.selector, data: sel_val};
        end
    end

    always_comb begin
        bus.data_out = '0;
        bus.out_sel  = '0;
        if (bus.out_valid) begin
            bus.data_out = head.data;
            bus.out_sel  = head.sel;
        end
    end

    assign bus.err_sel = err_q;
endmodule
